// File: rtl/sound_event_scheduler.sv
// -----------------------------------------------------------------------------
// sound_event_scheduler
//
// Purpose:
//   Turns the three dragon collision flags into timed voice enables for the
//   APU. Only one voice sounds at a time: noise (player-dragon) beats square
//   (sword-dragon), which beats saw (sheep-dragon). Each sound lasts a fixed
//   number of frame_end ticks and is followed by GAP_FRAMES silent ticks.
//
// Optional feature (macro SOUND_PREEMPT_EN):
//   Defined   - a higher-priority pending voice cuts off the current voice at
//               the next clock edge, with no gap. The cut-off voice is dropped.
//   Undefined - higher-priority events wait until the current voice and its
//               gap have finished.
//
// Ports:
//   clk                    in   system clock
//   reset                  in   asynchronous, active-high reset
//   SheepDragonCollision   in   level flag, rising edge requests the saw voice
//   SwordDragonCollision   in   level flag, rising edge requests the square voice
//   PlayerDragonCollision  in   level flag, rising edge requests the noise voice
//   frame_end              in   one-cycle tick per video frame
//   saw_en                 out  saw voice enable
//   square_en              out  square voice enable
//   noise_en               out  noise voice enable
//   active_id              out  playing voice: 0 none, 1 saw, 2 square, 3 noise
//   busy                   out  high whenever the scheduler is not IDLE
//   state_dbg              out  FSM state for debug: 0 IDLE, 1 PLAY, 2 GAP
//
// Handshake: there is none; collision flags are plain levels and only their
// rising edges matter. A flag held high produces exactly one request.
// -----------------------------------------------------------------------------
module sound_event_scheduler #(
    parameter int SAW_FRAMES    = 8,
    parameter int SQUARE_FRAMES = 12,
    parameter int NOISE_FRAMES  = 20,
    parameter int GAP_FRAMES    = 2,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SheepDragonCollision,
    input  logic       SwordDragonCollision,
    input  logic       PlayerDragonCollision,
    input  logic       frame_end,
    output logic       saw_en,
    output logic       square_en,
    output logic       noise_en,
    output logic [1:0] active_id,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // A zero duration would leave the counter stuck, so it plays for one tick.
    localparam logic [CNT_W-1:0] SAW_LOAD =
        (SAW_FRAMES == 0) ? CNT_W'(1) : CNT_W'(SAW_FRAMES);
    localparam logic [CNT_W-1:0] SQUARE_LOAD =
        (SQUARE_FRAMES == 0) ? CNT_W'(1) : CNT_W'(SQUARE_FRAMES);
    localparam logic [CNT_W-1:0] NOISE_LOAD =
        (NOISE_FRAMES == 0) ? CNT_W'(1) : CNT_W'(NOISE_FRAMES);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               HAS_GAP   = (GAP_FRAMES > 0);

    // Channel bit order everywhere: [0] saw, [1] square, [2] noise.
    // Voice id k (1..3) corresponds to channel bit k-1.
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       id_q, id_n;
    logic [2:0]       prev_q;
    logic [2:0]       pending_q, pending_n;

    logic [2:0]       col;
    logic [2:0]       evt;
    logic [1:0]       hi_pend_id;
    logic             preempt;
    logic [2:0]       clr_mask;
    logic [2:0]       evt_keep;

    // Duration to load for a voice id.
    function automatic logic [CNT_W-1:0] dur_of(input logic [1:0] id);
        logic [CNT_W-1:0] d;
        case (id)
            2'd1:    d = SAW_LOAD;
            2'd2:    d = SQUARE_LOAD;
            2'd3:    d = NOISE_LOAD;
            default: d = CNT_ONE;
        endcase
        return d;
    endfunction

    // Channel bit for a voice id; id 0 selects nothing.
    function automatic logic [2:0] mask_of(input logic [1:0] id);
        logic [2:0] m;
        case (id)
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b010;
            2'd3:    m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

    assign col = {PlayerDragonCollision, SwordDragonCollision, SheepDragonCollision};
    assign evt = col & ~prev_q;

    // Fixed priority: noise > square > saw.
    always_comb begin
        if (pending_q[2]) begin
            hi_pend_id = 2'd3;
        end else if (pending_q[1]) begin
            hi_pend_id = 2'd2;
        end else if (pending_q[0]) begin
            hi_pend_id = 2'd1;
        end else begin
            hi_pend_id = 2'd0;
        end
    end

`ifdef SOUND_PREEMPT_EN
    // Voice ids are ordered by priority, so a numeric compare is enough.
    assign preempt = (state == ST_PLAY) && (hi_pend_id > id_q);
`else
    assign preempt = 1'b0;
`endif

    // Next-state, counter and pending logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        id_n     = id_q;
        clr_mask = 3'b000;
        evt_keep = evt;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (hi_pend_id != 2'd0) begin
                    // A fresh edge on the channel being granted is absorbed:
                    // the sound starts from its full duration anyway.
                    clr_mask = mask_of(hi_pend_id);
                    evt_keep = evt & ~mask_of(hi_pend_id);
                    id_n     = hi_pend_id;
                    cnt_n    = dur_of(hi_pend_id);
                    state_n  = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (preempt) begin
                    // Takeover: the interrupted voice is simply forgotten.
                    clr_mask = mask_of(hi_pend_id);
                    id_n     = hi_pend_id;
                    cnt_n    = dur_of(hi_pend_id);
                end else if ((evt & mask_of(id_q)) != 3'b000) begin
                    // Retrigger wins over a coincident final tick.
                    evt_keep = evt & ~mask_of(id_q);
                    cnt_n    = dur_of(id_q);
                end else if (frame_end) begin
                    if (cnt == CNT_ONE) begin
                        id_n = 2'd0;
                        if (HAS_GAP) begin
                            state_n = ST_GAP;
                            cnt_n   = GAP_LOAD;
                        end else begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
            end

            ST_GAP: begin
                if (frame_end) begin
                    if (cnt == CNT_ONE) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                id_n    = 2'd0;
            end
        endcase

        pending_n = (pending_q & ~clr_mask) | evt_keep;
    end

    // prev resets high so a flag already asserted at reset release is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            id_q      <= 2'd0;
            prev_q    <= 3'b111;
            pending_q <= 3'b000;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            id_q      <= id_n;
            prev_q    <= col;
            pending_q <= pending_n;
        end
    end

    // Enables decode the registered id, so at most one can be high.
    assign active_id = id_q;
    assign saw_en    = (id_q == 2'd1);
    assign square_en = (id_q == 2'd2);
    assign noise_en  = (id_q == 2'd3);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sound_event_scheduler
//
// Self-checking bench for sound_event_scheduler with default parameters.
// A behavioural model (pending flags, a remaining-tick count and a phase)
// predicts every output each cycle; directed scenarios add hand-computed
// tick counts and latency checks. Honors SOUND_PREEMPT_EN when defined.
// -----------------------------------------------------------------------------
module tb_sound_event_scheduler;

  localparam int SAW_N   = 8;
  localparam int SQ_N    = 12;
  localparam int NOISE_N = 20;
  localparam int GAP_N   = 2;
`ifdef SOUND_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic       sheep, sword, player, frame_end;
  logic       saw_en, square_en, noise_en, busy;
  logic [1:0] active_id, state_dbg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sound_event_scheduler dut (
    .clk                  (clk),
    .reset                (reset),
    .SheepDragonCollision (sheep),
    .SwordDragonCollision (sword),
    .PlayerDragonCollision(player),
    .frame_end            (frame_end),
    .saw_en               (saw_en),
    .square_en            (square_en),
    .noise_en             (noise_en),
    .active_id            (active_id),
    .busy                 (busy),
    .state_dbg            (state_dbg)
  );

  // frame_end: one cycle high out of every ten
  initial begin
    int ph;
    ph = 0;
    frame_end = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 10;
      frame_end = (ph == 0);
    end
  end

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;
  int t_saw = 0, t_sq = 0, t_noise = 0, t_gap = 0, t_busy = 0;

  // ---------------- behavioural model ----------------
  int m_phase;          // 0 idle, 1 playing, 2 silent gap
  int m_play;           // voice id playing, 0 when none
  int m_left;           // ticks still to play
  int m_gap;            // gap ticks still to wait
  bit m_pend [1:3];
  bit m_prev [1:3];

  function automatic int dur(input int k);
    case (k)
      1:       return SAW_N;
      2:       return SQ_N;
      default: return NOISE_N;
    endcase
  endfunction

  function automatic bit in_of(input int k);
    case (k)
      1:       return sheep;
      2:       return sword;
      default: return player;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_play = 0; m_left = 0; m_gap = 0;
    for (int k = 1; k <= 3; k++) begin
      m_pend[k] = 1'b0;
      m_prev[k] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit ev [1:3];
    int hi;
    hi = 0;
    for (int k = 1; k <= 3; k++) begin
      ev[k] = in_of(k) && !m_prev[k];
      m_prev[k] = in_of(k);
      if (m_pend[k]) hi = k;
    end
    if (m_phase == 0) begin
      if (hi != 0) begin
        m_pend[hi] = 1'b0;
        ev[hi] = 1'b0;
        m_play = hi;
        m_left = dur(hi);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (PREEMPT && hi > m_play) begin
        m_pend[hi] = 1'b0;
        m_play = hi;
        m_left = dur(hi);
      end else if (ev[m_play]) begin
        ev[m_play] = 1'b0;
        m_left = dur(m_play);
      end else if (frame_end) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_play = 0;
          if (GAP_N > 0) begin
            m_phase = 2;
            m_gap = GAP_N;
          end else begin
            m_phase = 0;
          end
        end
      end
    end else begin
      if (frame_end) begin
        m_gap = m_gap - 1;
        if (m_gap == 0) m_phase = 0;
      end
    end
    for (int k = 1; k <= 3; k++)
      if (ev[k]) m_pend[k] = 1'b1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    logic [7:0] exp_v, act_v;
    if (cmp_on) begin
      exp_v = {2'(m_phase), 2'(m_play), m_play == 1, m_play == 2, m_play == 3, m_phase != 0};
      act_v = {state_dbg, active_id, saw_en, square_en, noise_en, busy};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t: got state/id/saw/sq/noise/busy=%b expected %b",
                 $time, act_v, exp_v);
      end
      n_cmp++;
      if ($countones({saw_en, square_en, noise_en}) > 1) begin
        n_err++;
        $display("FAIL one_enable t=%0t: got enables %b expected at most one high",
                 $time, {saw_en, square_en, noise_en});
      end
    end
    if (frame_end && saw_en) t_saw++;
    if (frame_end && square_en) t_sq++;
    if (frame_end && noise_en) t_noise++;
    if (frame_end && busy && active_id == 2'd0) t_gap++;
    if (busy) t_busy++;
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int k);
    if (k == 1) sheep = 1'b1;
    else if (k == 2) sword = 1'b1;
    else player = 1'b1;
    cycle();
    if (k == 1) sheep = 1'b0;
    else if (k == 2) sword = 1'b0;
    else player = 1'b0;
  endtask

  function automatic int ticks_of(input int k);
    case (k)
      0:       return t_gap;
      1:       return t_saw;
      2:       return t_sq;
      default: return t_noise;
    endcase
  endfunction

  // wait until voice k has seen n more ticks than at 'base'
  task automatic wait_ticks(input int k, input int base, input int n, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      cycle();
      if (ticks_of(k) - base >= n) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d ticks expected %0d", name, ticks_of(k) - base, n);
    end
  endtask

  // wait for busy to stay low for three consecutive cycles
  task automatic wait_idle(input string name);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 3000 && quiet < 3; i++) begin
      cycle();
      if (!busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_idle_timeout: got busy=%0b expected 0", name, busy);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int b_saw, b_sq, b_noise, b_gap, b_busy;
    reset = 1'b1;
    sheep = 1'b0; sword = 1'b0; player = 1'b0;
    cycle();
    cmp_on = 1'b1;
    do_reset();
    check("reset_active_id", active_id, 0);
    check("reset_busy", busy, 0);

    // 1: single saw pulse
    b_saw = t_saw; b_gap = t_gap;
    pulse(1);
    check("t1_latency_pending_only", saw_en, 0);
    cycle();
    check("t1_saw_en_granted", saw_en, 1);
    check("t1_active_id", active_id, 1);
    wait_idle("t1");
    check("t1_saw_ticks", t_saw - b_saw, 8);
    check("t1_gap_ticks", t_gap - b_gap, 2);

    // 2: all three at once
    b_saw = t_saw; b_sq = t_sq; b_noise = t_noise; b_gap = t_gap;
    sheep = 1'b1; sword = 1'b1; player = 1'b1;
    cycle();
    sheep = 1'b0; sword = 1'b0; player = 1'b0;
    cycle();
    check("t2_first_is_noise", active_id, 3);
    wait_idle("t2");
    check("t2_noise_ticks", t_noise - b_noise, 20);
    check("t2_square_ticks", t_sq - b_sq, 12);
    check("t2_saw_ticks", t_saw - b_saw, 8);
    check("t2_gap_ticks", t_gap - b_gap, 6);

    // 3: noise request during saw
    b_saw = t_saw; b_noise = t_noise; b_gap = t_gap;
    pulse(1);
    wait_ticks(1, b_saw, 3, "t3_saw3");
    pulse(3);
    cycle();
    check("t3_noise_en_after_request", noise_en, PREEMPT ? 1 : 0);
    check("t3_saw_en_after_request", saw_en, PREEMPT ? 0 : 1);
    wait_idle("t3");
    check("t3_saw_ticks", t_saw - b_saw, PREEMPT ? 3 : 8);
    check("t3_noise_ticks", t_noise - b_noise, 20);
    check("t3_gap_ticks", t_gap - b_gap, PREEMPT ? 2 : 4);

    // 4: square retriggered after tick 10
    b_sq = t_sq;
    pulse(2);
    wait_ticks(2, b_sq, 10, "t4_sq10");
    pulse(2);
    wait_idle("t4");
    check("t4_square_ticks", t_sq - b_sq, 22);

    // 5: flag held across reset release
    sword = 1'b1;
    do_reset();
    b_busy = t_busy; b_sq = t_sq;
    repeat (40) cycle();
    check("t5_no_sound_held_flag", t_busy - b_busy, 0);
    sword = 1'b0;
    cycle();
    sword = 1'b1;
    cycle();
    cycle();
    check("t5_square_after_reraise", square_en, 1);
    sword = 1'b0;
    wait_idle("t5");
    check("t5_square_ticks", t_sq - b_sq, 12);

    // 6: reset in the middle of noise
    b_noise = t_noise;
    pulse(3);
    wait_ticks(3, b_noise, 5, "t6_noise5");
    #2 reset = 1'b1;
    #1;
    check("t6_async_outputs", {active_id, saw_en, square_en, noise_en, busy}, 0);
    cycle();
    cycle();
    reset = 1'b0;
    b_busy = t_busy;
    repeat (40) cycle();
    check("t6_stays_idle", t_busy - b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
